dmem_arbiter: RTL and testbench

//   Shares the single-port data memory between the MIPS core (CPU port) and a

---
 rtl/dmem_arbiter_if.sv | 21 ++
 rtl/dmem_arbiter.sv | 105 ++++++++++
 tb/tb_dmem_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter_if
// Requester-side handshake bundle (CPU or debug port) of the memory arbiter.
// Rev    : 1.0
// ============================================================================
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ready;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, addr, wdata, input ready, rdata);
  modport slave  (input req, we, addr, wdata, output ready, rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : dmem_arbiter
// Round-robin sharing of a single-port data memory between CPU and debug port.
// Rev    : 1.0
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  dmem_arbiter_if.slave     cpu,
  dmem_arbiter_if.slave     dbg,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              grant_owner,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [2:0] C_LAT_LOAD = 3'(MEM_LATENCY - 1);

  state_t     r_state;
  logic [2:0] r_count;
  logic       r_last_owner;
  logic       w_any_req;
  logic       w_pick_dbg;

  assign w_any_req  = cpu.req | dbg.req;
  // On contention the side that did not own the last txn wins; a lone requester always wins.
  assign w_pick_dbg = dbg.req & (~cpu.req | ~r_last_owner);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_last_owner <= 1'b1;
      mem_en       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      grant_owner  <= 1'b0;
      busy         <= 1'b0;
      cpu.ready    <= 1'b0;
      cpu.rdata    <= '0;
      dbg.ready    <= 1'b0;
      dbg.rdata    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            grant_owner <= w_pick_dbg;
            mem_en      <= 1'b1;
            mem_we      <= w_pick_dbg ? dbg.we    : cpu.we;
            mem_addr    <= w_pick_dbg ? dbg.addr  : cpu.addr;
            mem_wdata   <= w_pick_dbg ? dbg.wdata : cpu.wdata;
            busy        <= 1'b1;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          r_count <= C_LAT_LOAD;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_count == 3'd0) begin
            if (grant_owner) begin
              dbg.ready <= 1'b1;
              dbg.rdata <= mem_rdata;
            end else begin
              cpu.ready <= 1'b1;
              cpu.rdata <= mem_rdata;
            end
            r_state <= S_DONE;
          end else begin
            r_count <= r_count - 3'd1;
          end
        end
        S_DONE: begin
          cpu.ready    <= 1'b0;
          dbg.ready    <= 1'b0;
          r_last_owner <= grant_owner;
          busy         <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_dmem_arbiter
// Scoreboard bench: one arbiter at MEM_LATENCY=1 (A) and one at 4 (B).
// Rev    : 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_arbiter;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    bit          owner;
    bit          chk;
    logic [31:0] data;
    int          cyc;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) cpu_a(), dbg_a(), cpu_b(), dbg_b();

  logic        mem_en_a, mem_we_a, grant_a, busy_a;
  logic [31:0] mem_addr_a, mem_wdata_a, mem_rdata_a;
  logic        mem_en_b, mem_we_b, grant_b, busy_b;
  logic [31:0] mem_addr_b, mem_wdata_b, mem_rdata_b;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(1)) dut_a (
    .clock(clock), .reset(reset), .cpu(cpu_a.slave), .dbg(dbg_a.slave),
    .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a),
    .mem_wdata(mem_wdata_a), .mem_rdata(mem_rdata_a),
    .grant_owner(grant_a), .busy(busy_a)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LATENCY(4)) dut_b (
    .clock(clock), .reset(reset), .cpu(cpu_b.slave), .dbg(dbg_b.slave),
    .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b),
    .mem_wdata(mem_wdata_b), .mem_rdata(mem_rdata_b),
    .grant_owner(grant_b), .busy(busy_b)
  );

  // Memory models: 256 words, unwritten words read a fixed address-derived pattern.
  logic [31:0] mem_a [256];
  bit          written_a [256];
  logic [31:0] pipe_a;
  logic [31:0] mem_b [256];
  bit          written_b [256];
  logic [31:0] pipe_b [4];

  function automatic logic [31:0] init_pat(input logic [31:0] addr);
    return {addr[15:0], ~addr[15:0]} ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] rd_a(input logic [31:0] addr);
    return written_a[addr[9:2]] ? mem_a[addr[9:2]] : init_pat(addr);
  endfunction

  function automatic logic [31:0] rd_b(input logic [31:0] addr);
    return written_b[addr[9:2]] ? mem_b[addr[9:2]] : init_pat(addr);
  endfunction

  always @(posedge clock) begin
    pipe_a <= (mem_en_a && !mem_we_a) ? rd_a(mem_addr_a) : 32'hBAD0_BAD0;
    if (mem_en_a && mem_we_a) begin
      mem_a[mem_addr_a[9:2]]     <= mem_wdata_a;
      written_a[mem_addr_a[9:2]] <= 1'b1;
    end
  end
  assign mem_rdata_a = pipe_a;

  always @(posedge clock) begin
    pipe_b[0] <= (mem_en_b && !mem_we_b) ? rd_b(mem_addr_b) : 32'hBAD0_BAD0;
    for (int i = 1; i < 4; i++) pipe_b[i] <= pipe_b[i-1];
    if (mem_en_b && mem_we_b) begin
      mem_b[mem_addr_b[9:2]]     <= mem_wdata_b;
      written_b[mem_addr_b[9:2]] <= 1'b1;
    end
  end
  assign mem_rdata_b = pipe_b[3];

  task automatic drv(input bit on_b, input bit is_dbg, input bit req, input bit we,
                     input logic [31:0] addr, input logic [31:0] wd);
    if (!on_b && !is_dbg) begin cpu_a.req = req; cpu_a.we = we; cpu_a.addr = addr; cpu_a.wdata = wd; end
    if (!on_b &&  is_dbg) begin dbg_a.req = req; dbg_a.we = we; dbg_a.addr = addr; dbg_a.wdata = wd; end
    if ( on_b && !is_dbg) begin cpu_b.req = req; cpu_b.we = we; cpu_b.addr = addr; cpu_b.wdata = wd; end
    if ( on_b &&  is_dbg) begin dbg_b.req = req; dbg_b.we = we; dbg_b.addr = addr; dbg_b.wdata = wd; end
  endtask

  task automatic push(input bit on_b, input bit owner, input bit chk, input logic [31:0] data, input int cyc);
    exp_t e;
    e.owner = owner; e.chk = chk; e.data = data; e.cyc = cyc;
    if (on_b) sb_b.push_back(e); else sb_a.push_back(e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drv(0, 0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      drv(0, 1, 1'($urandom), 1'($urandom), $urandom, $urandom);
      drv(1, 0, 1'($urandom), 1'($urandom), $urandom, $urandom);
      drv(1, 1, 1'($urandom), 1'($urandom), $urandom, $urandom);
      @(negedge clock);
      vectors++;
      if ({mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a, grant_a, busy_a,
           cpu_a.ready, cpu_a.rdata, dbg_a.ready, dbg_a.rdata} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs_a cycle %0d: busy=%b mem_en=%b addr=%h, required all 0",
                 i, busy_a, mem_en_a, mem_addr_a);
      end
      vectors++;
      if ({mem_en_b, mem_we_b, mem_addr_b, mem_wdata_b, grant_b, busy_b,
           cpu_b.ready, cpu_b.rdata, dbg_b.ready, dbg_b.rdata} !== '0) begin
        miscompares++;
        $display("FAIL reset_outputs_b cycle %0d: busy=%b mem_en=%b addr=%h, required all 0",
                 i, busy_b, mem_en_b, mem_addr_b);
      end
    end
    drv(0, 0, 0, 0, 0, 0); drv(0, 1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0); drv(1, 1, 0, 0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_cpu_write();
    exp_t e;
    push(0, 0, 0, 32'h0, 3);
    drv(0, 0, 1, 1, 32'h10, 32'hDEAD_BEEF);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (c == 1) begin
        vectors++;
        if ({mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a} !== {1'b1, 1'b1, 32'h10, 32'hDEAD_BEEF}) begin
          miscompares++;
          $display("FAIL cpu_write_access: en=%b we=%b addr=%h wdata=%h, required 1 1 00000010 deadbeef",
                   mem_en_a, mem_we_a, mem_addr_a, mem_wdata_a);
        end
      end
      if (cpu_a.ready || dbg_a.ready) begin
        vectors++;
        e = sb_a.pop_front();
        if (dbg_a.ready !== e.owner || c != e.cyc || grant_a !== e.owner) begin
          miscompares++;
          $display("FAIL cpu_write_ready: dbg_ready=%b cycle=%0d grant=%b, required owner %0d cycle %0d",
                   dbg_a.ready, c, grant_a, e.owner, e.cyc);
        end
        drv(0, 0, 0, 0, 0, 0);
      end
    end
    vectors++;
    if (sb_a.size() != 0) begin
      miscompares++;
      $display("FAIL cpu_write_timeout: %0d ready pulses missing, required 0", sb_a.size());
      sb_a.delete();
    end
  endtask

  task automatic test_dbg_read();
    exp_t e;
    bit   cpu_seen = 1'b0;
    push(0, 1, 1, 32'hDEAD_BEEF, 3);
    drv(0, 1, 1, 0, 32'h10, 32'h0);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock);
      if (cpu_a.ready) cpu_seen = 1'b1;
      if (c == 1) begin
        vectors++;
        if ({mem_en_a, mem_we_a, grant_a} !== 3'b101) begin
          miscompares++;
          $display("FAIL dbg_read_access: en=%b we=%b grant=%b, required 1 0 1", mem_en_a, mem_we_a, grant_a);
        end
      end
      if (dbg_a.ready) begin
        vectors++;
        e = sb_a.pop_front();
        if (c != e.cyc || dbg_a.rdata !== e.data || grant_a !== e.owner) begin
          miscompares++;
          $display("FAIL dbg_read_ready: cycle=%0d rdata=%h grant=%b, required cycle %0d rdata %h grant %0d",
                   c, dbg_a.rdata, grant_a, e.cyc, e.data, e.owner);
        end
        drv(0, 1, 0, 0, 0, 0);
      end
    end
    vectors++;
    if (cpu_seen || sb_a.size() != 0) begin
      miscompares++;
      $display("FAIL dbg_read_owner: cpu_ready_seen=%b missing=%0d, required 0 0", cpu_seen, sb_a.size());
      sb_a.delete();
    end
  endtask

  task automatic test_fairness();
    exp_t e;
    int   n_en = 0;
    reset = 1'b0;
    @(negedge clock);
    drv(0, 0, 1, 0, 32'h10, 32'h0);
    drv(0, 1, 1, 0, 32'h24, 32'h0);
    push(0, 0, 1, 32'hDEAD_BEEF, 3);
    push(0, 1, 1, rd_a(32'h24), 7);
    push(0, 0, 1, 32'hDEAD_BEEF, 11);
    push(0, 1, 1, rd_a(32'h24), 15);
    reset = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      if (mem_en_a) n_en++;
      if (cpu_a.ready || dbg_a.ready) begin
        vectors++;
        if (sb_a.size() == 0) begin
          miscompares++;
          $display("FAIL fairness_extra: unexpected ready at cycle %0d, required none", c);
        end else begin
          e = sb_a.pop_front();
          if (cpu_a.ready && dbg_a.ready || dbg_a.ready !== e.owner || c != e.cyc ||
              (e.owner ? dbg_a.rdata : cpu_a.rdata) !== e.data) begin
            miscompares++;
            $display("FAIL fairness_grant: cycle=%0d cpu_rdy=%b dbg_rdy=%b, required owner %0d cycle %0d data %h",
                     c, cpu_a.ready, dbg_a.ready, e.owner, e.cyc, e.data);
          end
          if (sb_a.size() == 0) begin drv(0, 0, 0, 0, 0, 0); drv(0, 1, 0, 0, 0, 0); end
        end
      end
    end
    vectors++;
    if (n_en != 4 || sb_a.size() != 0) begin
      miscompares++;
      $display("FAIL fairness_count: mem_en cycles=%0d missing=%0d, required 4 0", n_en, sb_a.size());
      sb_a.delete();
    end
  endtask

  task automatic test_latency4();
    exp_t e;
    push(1, 0, 1, rd_b(32'h40), 6);
    drv(1, 0, 1, 0, 32'h40, 32'h0);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clock);
      if (c == 2) drv(1, 0, 0, 1, 32'h44, 32'hFFFF_FFFF);
      if (c == 1) begin
        vectors++;
        if ({mem_en_b, mem_we_b, mem_addr_b} !== {1'b1, 1'b0, 32'h40}) begin
          miscompares++;
          $display("FAIL lat4_access: en=%b we=%b addr=%h, required 1 0 00000040", mem_en_b, mem_we_b, mem_addr_b);
        end
      end
      if (c == 4) begin
        vectors++;
        if ({busy_b, mem_en_b, mem_addr_b} !== {1'b1, 1'b0, 32'h40}) begin
          miscompares++;
          $display("FAIL lat4_wait: busy=%b en=%b addr=%h, required 1 0 00000040", busy_b, mem_en_b, mem_addr_b);
        end
      end
      if (cpu_b.ready || dbg_b.ready) begin
        vectors++;
        e = sb_b.pop_front();
        if (dbg_b.ready !== e.owner || c != e.cyc || cpu_b.rdata !== e.data) begin
          miscompares++;
          $display("FAIL lat4_ready: cycle=%0d rdata=%h, required cycle %0d rdata %h", c, cpu_b.rdata, e.cyc, e.data);
        end
      end
    end
    vectors++;
    if (sb_b.size() != 0) begin
      miscompares++;
      $display("FAIL lat4_timeout: %0d ready pulses missing, required 0", sb_b.size());
      sb_b.delete();
    end
  endtask

  task automatic test_reset_abort();
    exp_t e;
    drv(1, 0, 1, 0, 32'h40, 32'h0);
    drv(1, 1, 1, 0, 32'h48, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clock);
      if (c == 1) begin
        vectors++;
        if ({mem_en_b, grant_b} !== 2'b11) begin
          miscompares++;
          $display("FAIL abort_grant: en=%b grant=%b, required 1 1", mem_en_b, grant_b);
        end
      end
    end
    reset = 1'b0;
    #1;
    vectors++;
    if ({mem_en_b, busy_b, grant_b} !== 3'b000) begin
      miscompares++;
      $display("FAIL abort_immediate: en=%b busy=%b grant=%b, required 0 0 0", mem_en_b, busy_b, grant_b);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      vectors++;
      if (cpu_b.ready || dbg_b.ready || busy_b) begin
        miscompares++;
        $display("FAIL abort_no_ready: cpu_rdy=%b dbg_rdy=%b busy=%b, required 0 0 0", cpu_b.ready, dbg_b.ready, busy_b);
      end
    end
    push(1, 0, 1, rd_b(32'h40), 6);
    push(1, 1, 1, rd_b(32'h48), 13);
    reset = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      @(negedge clock);
      if (cpu_b.ready || dbg_b.ready) begin
        vectors++;
        if (sb_b.size() == 0) begin
          miscompares++;
          $display("FAIL abort_extra: unexpected ready at cycle %0d, required none", c);
        end else begin
          e = sb_b.pop_front();
          if (dbg_b.ready !== e.owner || c != e.cyc || (e.owner ? dbg_b.rdata : cpu_b.rdata) !== e.data) begin
            miscompares++;
            $display("FAIL abort_restart: cycle=%0d dbg_rdy=%b, required owner %0d cycle %0d data %h",
                     c, dbg_b.ready, e.owner, e.cyc, e.data);
          end
          if (sb_b.size() == 0) begin drv(1, 0, 0, 0, 0, 0); drv(1, 1, 0, 0, 0, 0); end
        end
      end
    end
    vectors++;
    if (sb_b.size() != 0) begin
      miscompares++;
      $display("FAIL abort_timeout: %0d ready pulses missing, required 0", sb_b.size());
      sb_b.delete();
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int   n_en = 0;
    int   n_rdy = 0;
    for (int k = 0; k < 3; k++) push(0, 1, 0, 32'h0, 3 + 4 * k);
    drv(0, 1, 1, 1, 32'h0, 32'h1111_0000);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clock);
      if (mem_en_a) begin
        vectors++;
        if ({mem_we_a, mem_addr_a, mem_wdata_a} !== {1'b1, 32'(4 * n_en), 32'h1111_0000 + 32'(n_en)}) begin
          miscompares++;
          $display("FAIL burst_addr: txn %0d we=%b addr=%h wdata=%h, required 1 %h %h",
                   n_en, mem_we_a, mem_addr_a, mem_wdata_a, 4 * n_en, 32'h1111_0000 + 32'(n_en));
        end
        n_en++;
      end
      if (cpu_a.ready || dbg_a.ready) begin
        vectors++;
        if (sb_a.size() == 0) begin
          miscompares++;
          $display("FAIL burst_extra: unexpected ready at cycle %0d, required none", c);
        end else begin
          e = sb_a.pop_front();
          if (dbg_a.ready !== e.owner || c != e.cyc) begin
            miscompares++;
            $display("FAIL burst_ready: cycle=%0d dbg_rdy=%b, required cycle %0d on dbg", c, dbg_a.ready, e.cyc);
          end
        end
        n_rdy++;
        if (n_rdy < 3) drv(0, 1, 1, 1, 32'(4 * n_rdy), 32'h1111_0000 + 32'(n_rdy));
        else           drv(0, 1, 0, 0, 0, 0);
      end
    end
    vectors++;
    if (n_en != 3 || sb_a.size() != 0 || !written_a[2] || mem_a[2] !== 32'h1111_0002) begin
      miscompares++;
      $display("FAIL burst_commit: mem_en=%0d missing=%0d word8=%h, required 3 0 11110002",
               n_en, sb_a.size(), mem_a[2]);
      sb_a.delete();
    end
  endtask

  initial begin
    drv(0, 0, 0, 0, 0, 0); drv(0, 1, 0, 0, 0, 0);
    drv(1, 0, 0, 0, 0, 0); drv(1, 1, 0, 0, 0, 0);
    test_reset();
    test_cpu_write();
    test_dbg_read();
    test_fairness();
    test_latency4();
    test_reset_abort();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
